// File: rtl/trace_log_arbiter.sv
// Per-message round-robin arbiter merging N byte streams into one line-wrapped trace stream.
// Optional TRACE_ARB_TAG_EN prefixes every message with a two-letter requester tag and ':'.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid requesters
// TAG0  | emit tag high letter (TRACE_ARB_TAG_EN only)
// TAG1  | emit tag low letter (TRACE_ARB_TAG_EN only)
// TAGC  | emit ':' separator (TRACE_ARB_TAG_EN only)
// BODY  | forward owner bytes until last
// WRAP  | line full: insert '\n', owner stalled
// EOL   | message ended without '\n': append one
module trace_log_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LINE_LEN = 76,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 out_valid_o,
    output logic [7:0]           out_data_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic [ID_W-1:0]      grant_id_o
);

    localparam logic [7:0] CHAR_NL  = 8'h0A;
    localparam logic [7:0] LINE_MAX = 8'(LINE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef TRACE_ARB_TAG_EN
        S_TAG0,
        S_TAG1,
        S_TAGC,
`endif
        S_BODY,
        S_WRAP,
        S_EOL
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] rr_q;
    logic [7:0]      col_q;
    logic            out_valid_q;
    logic [7:0]      out_data_q;

    logic            slot_free;
    logic            arb_found;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] rr_next;
    logic [ID_W:0]   arb_sum;
    logic [ID_W-1:0] arb_cand;
    logic            gnt_valid;
    logic            gnt_last;
    logic [7:0]      gnt_data;
    logic            grant_en;
    logic            load;
    logic [7:0]      load_data;

    assign slot_free   = !out_valid_q || out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != S_IDLE);
    assign grant_id_o  = grant_q;

    // Search from rr_q upward with wrap; first valid requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        arb_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, rr_q} + (ID_W+1)'(i);
            if (arb_sum >= (ID_W+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
            end
            arb_cand = arb_sum[ID_W-1:0];
            if (!arb_found && req_valid_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    assign rr_next = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == ID_W'(k)) begin
                gnt_valid = req_valid_i[k];
                gnt_last  = req_last_i[k];
                gnt_data  = req_data_i[8*k +: 8];
            end
        end
    end

`ifdef TRACE_ARB_TAG_EN
    logic [7:0] tag_hi;
    logic [7:0] tag_lo;

    assign tag_hi = 8'(97 + int'(grant_q) / 26);
    assign tag_lo = 8'(97 + int'(grant_q) % 26);
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        grant_en    = 1'b0;
        load        = 1'b0;
        load_data   = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_en = 1'b1;
`ifdef TRACE_ARB_TAG_EN
                    state_d  = S_TAG0;
`else
                    state_d  = S_BODY;
`endif
                end
            end
`ifdef TRACE_ARB_TAG_EN
            S_TAG0: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = tag_hi;
                    state_d   = S_TAG1;
                end
            end
            S_TAG1: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = tag_lo;
                    state_d   = S_TAGC;
                end
            end
            S_TAGC: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = 8'h3A;
                    state_d   = S_BODY;
                end
            end
`endif
            S_BODY: begin
                if (col_q == LINE_MAX) begin
                    state_d = S_WRAP;
                end else begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        req_ready_o[k] = slot_free && (grant_q == ID_W'(k));
                    end
                    if (slot_free && gnt_valid) begin
                        load      = 1'b1;
                        load_data = gnt_data;
                        // A message already closed by its own '\n' needs no EOL.
                        if (gnt_last) begin
                            state_d = (gnt_data == CHAR_NL) ? S_IDLE : S_EOL;
                        end
                    end
                end
            end
            S_WRAP: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = CHAR_NL;
                    state_d   = S_BODY;
                end
            end
            S_EOL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = CHAR_NL;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            col_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                grant_q <= arb_idx;
                rr_q    <= rr_next;
            end
            if (slot_free) begin
                out_valid_q <= load;
            end
            if (load) begin
                out_data_q <= load_data;
                col_q      <= (load_data == CHAR_NL) ? 8'h00 : col_q + 8'd1;
            end
        end
    end

endmodule
